// File: rtl/csr_pkg.sv
// Shared CSR definitions: funct3 encodings, FSM states, CSR addresses.
package csr_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned IDX_W  = 5;

    localparam logic [F3_W-1:0] F3_RW  = 3'b001;
    localparam logic [F3_W-1:0] F3_RS  = 3'b010;
    localparam logic [F3_W-1:0] F3_RC  = 3'b011;
    localparam logic [F3_W-1:0] F3_RWI = 3'b101;
    localparam logic [F3_W-1:0] F3_RSI = 3'b110;
    localparam logic [F3_W-1:0] F3_RCI = 3'b111;

    localparam logic [ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [ADDR_W-1:0] CSR_MVENDORID = 12'hF11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // 000 and 100 are the only unused CSR encodings.
    function automatic logic f3_valid(input logic [F3_W-1:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/csr_exec_if.sv
// Request/response handshake bundle between the core and csr_exec.
interface csr_exec_if
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [F3_W-1:0]      req_funct3;
    logic [ADDR_W-1:0]    req_addr;
    logic [XLEN-1:0]      req_rs1_val;
    logic [IDX_W-1:0]     req_rs1_idx;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [XLEN-1:0]      resp_rdata;
    logic                 resp_illegal;

    modport master (
        output req_valid, req_funct3, req_addr, req_rs1_val, req_rs1_idx, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_illegal
    );

    modport slave (
        input  req_valid, req_funct3, req_addr, req_rs1_val, req_rs1_idx, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_illegal
    );
endinterface

// File: rtl/csr_alu.sv
// Combinational CSR read-modify-write: op 01 write, 10 set, 11 clear.
module csr_alu
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] new_val_c
);

    // Select the new CSR value from the old value and the operand.
    always_comb begin
        new_val_c = operand;
        case (op)
            2'b10:   new_val_c = old_val | operand;
            2'b11:   new_val_c = old_val & ~operand;
            default: new_val_c = operand;
        endcase
    end

endmodule

// File: rtl/csr_exec.sv
// CSR instruction sequencer: accept, read, optional write, respond.
// Optional build macro CSR_RO_CHECK_EN: writes to read-only CSRs
// (addr[11:10] == 2'b11) are flagged illegal instead of issued.
module csr_exec
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rstl,
    csr_exec_if.slave         bus,
    output logic              csr_w,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_din,
    input  logic [XLEN-1:0]   csr_dout
);

    state_t            state;
    logic [1:0]        op;
    logic [IDX_W-1:0]  idx;
    logic [XLEN-1:0]   operand;
    logic [XLEN-1:0]   old_val;
    logic [XLEN-1:0]   new_val_c;
    logic              write_needed_c;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .op        (op),
        .old_val   (csr_dout),
        .operand   (operand),
        .new_val_c (new_val_c)
    );

    // Plain writes always write; set/clear only when rs1/zimm is nonzero.
    assign write_needed_c = (op == F3_RW[1:0]) || (idx != '0);

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            state            <= S_IDLE;
            op               <= 2'b00;
            idx              <= '0;
            operand          <= '0;
            old_val          <= '0;
            csr_w            <= 1'b0;
            csr_addr         <= '0;
            csr_din          <= '0;
            bus.req_ready    <= 1'b1;
            bus.resp_valid   <= 1'b0;
            bus.resp_rdata   <= '0;
            bus.resp_illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op            <= bus.req_funct3[1:0];
                        idx           <= bus.req_rs1_idx;
                        csr_addr      <= bus.req_addr;
                        operand       <= bus.req_funct3[2] ? XLEN'(bus.req_rs1_idx)
                                                           : bus.req_rs1_val;
                        bus.req_ready <= 1'b0;
                        if (f3_valid(bus.req_funct3)) begin
                            state <= S_READ;
                        end else begin
                            state            <= S_RESP;
                            bus.resp_valid   <= 1'b1;
                            bus.resp_illegal <= 1'b1;
                            bus.resp_rdata   <= '0;
                        end
                    end
                end
                S_READ: begin
                    old_val <= csr_dout;
                    if (write_needed_c) begin
`ifdef CSR_RO_CHECK_EN
                        if (csr_addr[11:10] == 2'b11) begin
                            state            <= S_RESP;
                            bus.resp_valid   <= 1'b1;
                            bus.resp_illegal <= 1'b1;
                            bus.resp_rdata   <= csr_dout;
                        end else begin
                            state   <= S_WRITE;
                            csr_w   <= 1'b1;
                            csr_din <= new_val_c;
                        end
`else
                        state   <= S_WRITE;
                        csr_w   <= 1'b1;
                        csr_din <= new_val_c;
`endif
                    end else begin
                        state            <= S_RESP;
                        bus.resp_valid   <= 1'b1;
                        bus.resp_illegal <= 1'b0;
                        bus.resp_rdata   <= csr_dout;
                    end
                end
                S_WRITE: begin
                    csr_w            <= 1'b0;
                    state            <= S_RESP;
                    bus.resp_valid   <= 1'b1;
                    bus.resp_illegal <= 1'b0;
                    bus.resp_rdata   <= old_val;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        state            <= S_IDLE;
                        bus.resp_valid   <= 1'b0;
                        bus.resp_illegal <= 1'b0;
                        bus.req_ready    <= 1'b1;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    csr_w         <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_exec.sv
// Directed bench for csr_exec with a two-register CSR file model.
module tb_csr_exec;
    import csr_pkg::*;

    logic        clk;
    logic        rstl;
    logic        csr_w;
    logic [11:0] csr_addr;
    logic [31:0] csr_din;
    logic [31:0] csr_dout;

    logic [31:0] mscratch;
    logic        pre_en;
    logic [31:0] pre_val;
    int          wr_cnt;
    logic [31:0] wr_din;

    int total;
    int bad;

    csr_exec_if #(.XLEN(32)) bus ();

    csr_exec #(.XLEN(32)) dut (
        .clk      (clk),
        .rstl     (rstl),
        .bus      (bus),
        .csr_w    (csr_w),
        .csr_addr (csr_addr),
        .csr_din  (csr_din),
        .csr_dout (csr_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: mscratch is read/write, mvendorid reads zero and ignores writes.
    assign csr_dout = (csr_addr == CSR_MSCRATCH) ? mscratch : 32'h0;

    always @(posedge clk) begin
        if (pre_en)
            mscratch <= pre_val;
        else if (csr_w && csr_addr == CSR_MSCRATCH)
            mscratch <= csr_din;
    end

    initial wr_cnt = 0;
    always @(posedge clk) begin
        if (csr_w === 1'b1) begin
            wr_cnt <= wr_cnt + 1;
            wr_din <= csr_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] v);
        pre_en  = 1'b1;
        pre_val = v;
        @(posedge clk); #1;
        pre_en  = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                          input logic [4:0] idx, output int lat, output logic [31:0] rd,
                          output logic ill, output int nwr, output logic [31:0] din);
        int base;
        base = wr_cnt;
        bus.req_valid   = 1'b1;
        bus.req_funct3  = f3;
        bus.req_addr    = a;
        bus.req_rs1_val = rs1;
        bus.req_rs1_idx = idx;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = bus.resp_rdata;
        ill = bus.resp_illegal;
        nwr = wr_cnt - base;
        din = wr_din;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        int          nwr;
        logic [31:0] rd;
        logic [31:0] din;
        logic        ill;

        total = 0;
        bad   = 0;
        pre_en = 1'b0;
        pre_val = '0;
        mscratch = '0;
        wr_din = '0;
        bus.req_valid = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr = '0;
        bus.req_rs1_val = '0;
        bus.req_rs1_idx = '0;
        bus.resp_ready = 1'b0;
        rstl = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstl = 1'b1;
        #1;

        // Reset values
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_illegal", 32'(bus.resp_illegal), 32'd0);
        check("rst_csr_w", 32'(csr_w), 32'd0);
        check("rst_csr_addr", 32'(csr_addr), 32'h0);
        check("rst_csr_din", csr_din, 32'h0);
        @(posedge clk); #1;

        // CSRRW mscratch
        preload(32'h1234_5678);
        do_req(F3_RW, CSR_MSCRATCH, 32'hDEAD_BEEF, 5'd1, lat, rd, ill, nwr, din);
        check("rw_lat", 32'(lat), 32'd3);
        check("rw_rdata", rd, 32'h1234_5678);
        check("rw_illegal", 32'(ill), 32'd0);
        check("rw_nwr", 32'(nwr), 32'd1);
        check("rw_din", din, 32'hDEAD_BEEF);
        check("rw_mscratch", mscratch, 32'hDEAD_BEEF);
        check("rw_ready_back", 32'(bus.req_ready), 32'd1);

        // CSRRS with x0: read only
        do_req(F3_RS, CSR_MSCRATCH, 32'hFFFF_FFFF, 5'd0, lat, rd, ill, nwr, din);
        check("rs0_lat", 32'(lat), 32'd2);
        check("rs0_rdata", rd, 32'hDEAD_BEEF);
        check("rs0_nwr", 32'(nwr), 32'd0);
        check("rs0_mscratch", mscratch, 32'hDEAD_BEEF);

        // CSRRCI zimm=5 on 0xF
        preload(32'h0000_000F);
        do_req(F3_RCI, CSR_MSCRATCH, 32'hFFFF_FFFF, 5'd5, lat, rd, ill, nwr, din);
        check("rci_lat", 32'(lat), 32'd3);
        check("rci_rdata", rd, 32'h0000_000F);
        check("rci_din", din, 32'h0000_000A);
        check("rci_mscratch", mscratch, 32'h0000_000A);

        // CSRRS with register operand, then CSRRC
        do_req(F3_RS, CSR_MSCRATCH, 32'h0000_0050, 5'd3, lat, rd, ill, nwr, din);
        check("rs_rdata", rd, 32'h0000_000A);
        check("rs_din", din, 32'h0000_005A);
        check("rs_nwr", 32'(nwr), 32'd1);
        do_req(F3_RC, CSR_MSCRATCH, 32'h0000_000A, 5'd2, lat, rd, ill, nwr, din);
        check("rc_rdata", rd, 32'h0000_005A);
        check("rc_din", din, 32'h0000_0050);

        // CSRRSI zimm=0: read only
        do_req(F3_RSI, CSR_MSCRATCH, 32'hFFFF_FFFF, 5'd0, lat, rd, ill, nwr, din);
        check("rsi0_lat", 32'(lat), 32'd2);
        check("rsi0_rdata", rd, 32'h0000_0050);
        check("rsi0_nwr", 32'(nwr), 32'd0);

        // CSRRWI zimm=31
        do_req(F3_RWI, CSR_MSCRATCH, 32'h0, 5'd31, lat, rd, ill, nwr, din);
        check("rwi_din", din, 32'h0000_001F);
        check("rwi_mscratch", mscratch, 32'h0000_001F);

        // CSRRW to read-only mvendorid
        do_req(F3_RW, CSR_MVENDORID, 32'h0000_0055, 5'd1, lat, rd, ill, nwr, din);
        check("ro_rdata", rd, 32'h0);
`ifdef CSR_RO_CHECK_EN
        check("ro_illegal", 32'(ill), 32'd1);
        check("ro_nwr", 32'(nwr), 32'd0);
        check("ro_lat", 32'(lat), 32'd2);
`else
        check("ro_illegal", 32'(ill), 32'd0);
        check("ro_nwr", 32'(nwr), 32'd1);
        check("ro_lat", 32'(lat), 32'd3);
        do_req(F3_RS, CSR_MVENDORID, 32'h0, 5'd0, lat, rd, ill, nwr, din);
        check("ro_readback", rd, 32'h0);
`endif
        check("ro_mscratch", mscratch, 32'h0000_001F);

        // Invalid funct3=100 with resp_ready held low
        begin
            int base;
            base = wr_cnt;
            bus.req_valid  = 1'b1;
            bus.req_funct3 = 3'b100;
            bus.req_addr   = CSR_MSCRATCH;
            bus.req_rs1_val = 32'h1111_1111;
            bus.req_rs1_idx = 5'd1;
            @(posedge clk); #1;
            check("inv_valid_lat1", 32'(bus.resp_valid), 32'd1);
            check("inv_illegal", 32'(bus.resp_illegal), 32'd1);
            check("inv_rdata", bus.resp_rdata, 32'h0);
            bus.req_funct3 = F3_RW;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                check("inv_hold_valid", 32'(bus.resp_valid), 32'd1);
                check("inv_hold_ready", 32'(bus.req_ready), 32'd0);
                check("inv_hold_illegal", 32'(bus.resp_illegal), 32'd1);
            end
            bus.req_valid = 1'b0;
            check("inv_nwr", 32'(wr_cnt - base), 32'd0);
            bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus.resp_ready = 1'b0;
            check("inv_done_valid", 32'(bus.resp_valid), 32'd0);
            check("inv_done_ready", 32'(bus.req_ready), 32'd1);
        end

        // funct3=000 also illegal
        do_req(3'b000, CSR_MSCRATCH, 32'h2222_2222, 5'd1, lat, rd, ill, nwr, din);
        check("f0_lat", 32'(lat), 32'd1);
        check("f0_illegal", 32'(ill), 32'd1);
        check("f0_nwr", 32'(nwr), 32'd0);

        // Reset asserted while in WRITE
        preload(32'h1234_5678);
        bus.req_valid   = 1'b1;
        bus.req_funct3  = F3_RW;
        bus.req_addr    = CSR_MSCRATCH;
        bus.req_rs1_val = 32'hCAFE_F00D;
        bus.req_rs1_idx = 5'd1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("wr_state_csr_w", 32'(csr_w), 32'd1);
        rstl = 1'b0;
        #1;
        check("rst_wr_csr_w", 32'(csr_w), 32'd0);
        @(posedge clk); #1;
        check("rst_wr_mscratch", mscratch, 32'h1234_5678);
        rstl = 1'b1;
        #1;
        check("rst_wr_ready", 32'(bus.req_ready), 32'd1);
        check("rst_wr_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        check("rst_wr_mscratch2", mscratch, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
